find_first_set_2d_scanner: RTL

Sequential successor to the combinational 2D first-set finder. The block accepts a full 2D bitmap through a valid/ready load handshake and then emits every set bit, one per cycle, in ascending row-then-column order. Each coordinate is emitted in both one-hot and binary form, with a running beat index and a last flag. It sits between the Image Resizer's mapping-mask generator and its per-pixel fetch engine, replacing the single-shot lookup with full mask enumeration.

---
 rtl/find_first_set_2d_scanner_if.sv | 37 +++
 rtl/find_first_set_2d_scanner.sv | 133 +++++++++++++
 2 files changed

// File: rtl/find_first_set_2d_scanner_if.sv
// Load/coordinate handshake bundle for the 2D first-set scanner.
// The master side drives the bitmap and accepts coordinate beats; the slave side is the scanner.
interface find_first_set_2d_scanner_if #(
    parameter int DATA_X_W = 7,
    parameter int DATA_Y_W = 5
);
    localparam int IDX_X_W = (DATA_X_W > 1) ? $clog2(DATA_X_W) : 1;
    localparam int IDX_Y_W = (DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1;
    localparam int CNT_W   = $clog2(DATA_X_W * DATA_Y_W + 1);

    logic                               Flush;
    logic [DATA_Y_W-1:0][DATA_X_W-1:0]  MapIn;
    logic                               MapValid;
    logic                               MapReady;
    logic                               CoordValid;
    logic                               CoordReady;
    logic [DATA_X_W-1:0]                CoordX;
    logic [DATA_Y_W-1:0]                CoordY;
    logic [IDX_X_W-1:0]                 CoordXIdx;
    logic [IDX_Y_W-1:0]                 CoordYIdx;
    logic [CNT_W-1:0]                   CoordCnt;
    logic                               CoordLast;
    logic                               Done;
    logic                               Busy;

    modport master (
        output Flush, MapIn, MapValid, CoordReady,
        input  MapReady, CoordValid, CoordX, CoordY, CoordXIdx, CoordYIdx,
               CoordCnt, CoordLast, Done, Busy
    );

    modport slave (
        input  Flush, MapIn, MapValid, CoordReady,
        output MapReady, CoordValid, CoordX, CoordY, CoordXIdx, CoordYIdx,
               CoordCnt, CoordLast, Done, Busy
    );
endinterface

// File: rtl/find_first_set_2d_scanner.sv
// Sequential 2D first-set scanner: loads a whole bitmap, then emits each set bit once per
// accepted beat in row-then-column order, clearing it from the working copy as it goes.
module find_first_set_2d_scanner #(
    parameter int DATA_X_W = 7,
    parameter int DATA_Y_W = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    find_first_set_2d_scanner_if.slave    bus
);
    localparam int IDX_X_W = (DATA_X_W > 1) ? $clog2(DATA_X_W) : 1;
    localparam int IDX_Y_W = (DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1;
    localparam int CNT_W   = $clog2(DATA_X_W * DATA_Y_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                             state;
    logic [DATA_Y_W-1:0][DATA_X_W-1:0]  work;
    logic [CNT_W-1:0]                   cnt;
    logic                               done;

    logic                               row_found;
    logic [DATA_Y_W-1:0]                row_hit;
    logic [IDX_Y_W-1:0]                 y_idx;
    logic [DATA_X_W-1:0]                sel_row;
    logic [DATA_X_W-1:0]                col_hit;
    logic [IDX_X_W-1:0]                 x_idx;
    logic [DATA_Y_W-1:0][DATA_X_W-1:0]  work_cleared;
    logic                               last_bit;
    logic                               in_scan;
    logic                               beat_xfer;

    // Pick the lowest row holding any set bit and capture that row's contents.
    always_comb begin
        row_found = 1'b0;
        row_hit   = '0;
        y_idx     = '0;
        sel_row   = '0;
        for (int y = 0; y < DATA_Y_W; y++) begin
            if (!row_found && (|work[y])) begin
                row_found  = 1'b1;
                row_hit[y] = 1'b1;
                y_idx      = IDX_Y_W'(y);
                sel_row    = work[y];
            end
        end
    end

    // Pick the lowest set column inside the selected row.
    always_comb begin
        col_hit = '0;
        x_idx   = '0;
        for (int x = DATA_X_W - 1; x >= 0; x--) begin
            if (sel_row[x]) begin
                col_hit    = '0;
                col_hit[x] = 1'b1;
                x_idx      = IDX_X_W'(x);
            end
        end
    end

    // Working map with the currently presented bit removed; empty means this is the last beat.
    always_comb begin
        work_cleared = work;
        for (int y = 0; y < DATA_Y_W; y++) begin
            work_cleared[y] = work[y] & ~(col_hit & {DATA_X_W{row_hit[y]}});
        end
    end

    assign last_bit  = row_found && (work_cleared == '0);
    assign in_scan   = (state == SCAN);
    assign beat_xfer = in_scan && !bus.Flush && bus.CoordReady;

    assign bus.MapReady   = (state == IDLE) && !bus.Flush;
    assign bus.CoordValid = in_scan && !bus.Flush;
    assign bus.CoordX     = in_scan ? col_hit : '0;
    assign bus.CoordY     = in_scan ? row_hit : '0;
    assign bus.CoordXIdx  = in_scan ? x_idx : '0;
    assign bus.CoordYIdx  = in_scan ? y_idx : '0;
    assign bus.CoordLast  = in_scan && last_bit;
    assign bus.CoordCnt   = cnt;
    assign bus.Done       = done;
    assign bus.Busy       = in_scan;

    // Control FSM: Flush beats everything, loads happen in IDLE, beats drain the map in SCAN.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.Flush) begin
                state <= IDLE;
                work  <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.MapValid) begin
                            work <= bus.MapIn;
                            cnt  <= '0;
                            if (bus.MapIn == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= SCAN;
                            end
                        end
                    end
                    SCAN: begin
                        if (beat_xfer) begin
                            work <= work_cleared;
                            if (last_bit) begin
                                state <= IDLE;
                                cnt   <= '0;
                                done  <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
